// File: rtl/dec_dly_comp_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// dec_dly_comp_ctrl_pkg
// Shared types and defaults for the delay-compensation config scheduler.
//   ctrl_state_t : controller FSM states
//   DEF_*        : default parameter values
//   clip_dly     : saturate a requested delay to the legal maximum
// ---------------------------------------------------------------------------
package dec_dly_comp_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        WRITE  = 2'd2,
        COMMIT = 2'd3
    } ctrl_state_t;

    localparam int DEF_N_CH    = 4;
    localparam int DEF_DLY_W   = 8;
    localparam int DEF_MAX_DLY = 200;
    localparam int DEF_CNT_W   = 16;

    // Delays above max_dly saturate rather than wrap.
    function automatic int clip_dly(input int dly, input int max_dly);
        return (dly > max_dly) ? max_dly : dly;
    endfunction

endpackage

// File: rtl/dec_dly_comp_ctrl_if.sv
// ---------------------------------------------------------------------------
// dec_dly_comp_ctrl_if
// Handshake bundle between the config scheduler, its channel requesters and
// the datapath delay table.
//   req_valid/req_dly/req_ready : per-channel update requests
//   cfg_wr_en/cfg_wr_ch/cfg_wr_dly : shadow delay-table write port
//   commit_req/commit_ack : shadow-to-active commit handshake
// modport master : the controller; modport slave : requesters + datapath.
// ---------------------------------------------------------------------------
interface dec_dly_comp_ctrl_if #(
    parameter int N_CH  = 4,
    parameter int DLY_W = 8
) ();
    localparam int CH_W = $clog2(N_CH);

    logic [N_CH-1:0]       req_valid;
    logic [N_CH*DLY_W-1:0] req_dly;
    logic [N_CH-1:0]       req_ready;
    logic                  cfg_wr_en;
    logic [CH_W-1:0]       cfg_wr_ch;
    logic [DLY_W-1:0]      cfg_wr_dly;
    logic                  commit_req;
    logic                  commit_ack;

    modport master (
        input  req_valid, req_dly, commit_ack,
        output req_ready, cfg_wr_en, cfg_wr_ch, cfg_wr_dly, commit_req
    );

    modport slave (
        output req_valid, req_dly, commit_ack,
        input  req_ready, cfg_wr_en, cfg_wr_ch, cfg_wr_dly, commit_req
    );
endinterface

// File: rtl/dec_dly_comp_rr_arb.sv
// ---------------------------------------------------------------------------
// dec_dly_comp_rr_arb
// Combinational round-robin selector: picks the first valid channel at or
// after ptr, wrapping around. The pointer register lives in the parent.
//   req_valid : per-channel request
//   ptr       : highest-priority channel this cycle
//   gnt       : selected channel (0 when none valid)
//   any_valid : at least one request present
// ---------------------------------------------------------------------------
module dec_dly_comp_rr_arb #(
    parameter int N_CH = 4,
    parameter int CH_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] req_valid,
    input  logic [CH_W-1:0] ptr,
    output logic [CH_W-1:0] gnt,
    output logic            any_valid
);
    logic [CH_W-1:0] idx;

    // Walk from the farthest offset back to the pointer so the closest
    // valid channel is the last (winning) assignment.
    always_comb begin
        gnt       = '0;
        any_valid = 1'b0;
        idx       = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            idx = CH_W'((int'(ptr) + k) % N_CH);
            if (req_valid[idx]) begin
                gnt       = idx;
                any_valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/dec_dly_comp_ctrl.sv
// ---------------------------------------------------------------------------
// dec_dly_comp_ctrl
// Config scheduler for the decimation delay-compensation datapath. Shares the
// single delay-table write port between N_CH requesters (round-robin), clips
// requested delays to MAX_DLY, and on frame sync sequences a shadow-to-active
// commit with a req/ack handshake.
//   clk, areset_n : clock, async active-low reset
//   bus           : requests, table write port, commit handshake (master)
//   sync_in       : frame sync pulse
//   err_clr       : clears sticky errors (a coincident set wins)
//   cfg_busy      : FSM not in IDLE
//   commit_cnt    : completed commits, wrapping
//   err_clip      : sticky, a request exceeded MAX_DLY
//   err_sync_ovr  : sticky, a sync was dropped
// ---------------------------------------------------------------------------
import dec_dly_comp_ctrl_pkg::*;

module dec_dly_comp_ctrl #(
    parameter int N_CH    = DEF_N_CH,
    parameter int DLY_W   = DEF_DLY_W,
    parameter int MAX_DLY = DEF_MAX_DLY,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic                clk,
    input  logic                areset_n,
    dec_dly_comp_ctrl_if.master bus,
    input  logic                sync_in,
    input  logic                err_clr,
    output logic                cfg_busy,
    output logic [CNT_W-1:0]    commit_cnt,
    output logic                err_clip,
    output logic                err_sync_ovr
);
    localparam int CH_W = $clog2(N_CH);

    ctrl_state_t      state;
    logic [CH_W-1:0]  ptr;
    logic [CH_W-1:0]  gnt_q;
    logic [CH_W-1:0]  arb_gnt;
    logic             arb_any;
    logic             sync_pend;
    logic [DLY_W-1:0] sel_dly;
    logic             clip_set;
    logic             ovr_set;

    dec_dly_comp_rr_arb #(.N_CH(N_CH), .CH_W(CH_W)) u_arb (
        .req_valid (bus.req_valid),
        .ptr       (ptr),
        .gnt       (arb_gnt),
        .any_valid (arb_any)
    );

    // Requesters hold data until they see req_ready, so the granted
    // channel's delay is still valid during GRANT.
    assign sel_dly  = bus.req_dly[int'(gnt_q)*DLY_W +: DLY_W];
    assign clip_set = (state == GRANT) && (int'(sel_dly) > MAX_DLY);
    // Only one sync can be queued; any sync while one is pending or a
    // commit is underway is lost.
    assign ovr_set  = sync_in && ((state == COMMIT) || sync_pend);

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state          <= IDLE;
            ptr            <= '0;
            gnt_q          <= '0;
            sync_pend      <= 1'b0;
            bus.req_ready  <= '0;
            bus.cfg_wr_en  <= 1'b0;
            bus.cfg_wr_ch  <= '0;
            bus.cfg_wr_dly <= '0;
            bus.commit_req <= 1'b0;
            cfg_busy       <= 1'b0;
            commit_cnt     <= '0;
            err_clip       <= 1'b0;
            err_sync_ovr   <= 1'b0;
        end else begin
            bus.req_ready <= '0;
            bus.cfg_wr_en <= 1'b0;
            err_clip      <= clip_set | (err_clip & ~err_clr);
            err_sync_ovr  <= ovr_set  | (err_sync_ovr & ~err_clr);
            if (sync_in && !ovr_set)
                sync_pend <= 1'b1;

            case (state)
                IDLE: begin
                    if (sync_pend) begin
                        state          <= COMMIT;
                        sync_pend      <= 1'b0;
                        bus.commit_req <= 1'b1;
                        cfg_busy       <= 1'b1;
                    end else if (arb_any) begin
                        state         <= GRANT;
                        gnt_q         <= arb_gnt;
                        bus.req_ready <= N_CH'(1) << arb_gnt;
                        cfg_busy      <= 1'b1;
                    end
                end
                GRANT: begin
                    state          <= WRITE;
                    bus.cfg_wr_en  <= 1'b1;
                    bus.cfg_wr_ch  <= gnt_q;
                    bus.cfg_wr_dly <= DLY_W'(clip_dly(int'(sel_dly), MAX_DLY));
                    ptr            <= (gnt_q == CH_W'(N_CH - 1)) ? '0 : gnt_q + CH_W'(1);
                end
                WRITE: begin
                    state    <= IDLE;
                    cfg_busy <= 1'b0;
                end
                COMMIT: begin
                    if (bus.commit_ack) begin
                        state          <= IDLE;
                        bus.commit_req <= 1'b0;
                        commit_cnt     <= commit_cnt + CNT_W'(1);
                        cfg_busy       <= 1'b0;
                    end
                end
                default: begin
                    state          <= IDLE;
                    bus.commit_req <= 1'b0;
                    cfg_busy       <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dec_dly_comp_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dec_dly_comp_ctrl
// Self-checking bench: expected table writes are queued when a request is
// driven and popped when cfg_wr_en appears; hand sequences cover round-robin,
// clipping, sync/commit handshake, overrun and reset during a commit.
// ---------------------------------------------------------------------------
module tb_dec_dly_comp_ctrl;
    localparam int N    = 4;
    localparam int W    = 8;
    localparam int CW   = 16;

    logic          clk = 1'b0;
    logic          areset_n = 1'b0;
    logic          sync_in = 1'b0;
    logic          err_clr = 1'b0;
    logic          cfg_busy;
    logic [CW-1:0] commit_cnt;
    logic          err_clip;
    logic          err_sync_ovr;

    dec_dly_comp_ctrl_if #(.N_CH(N), .DLY_W(W)) ifc ();

    dec_dly_comp_ctrl #(.N_CH(N), .DLY_W(W), .MAX_DLY(200), .CNT_W(CW)) dut (
        .clk          (clk),
        .areset_n     (areset_n),
        .bus          (ifc.master),
        .sync_in      (sync_in),
        .err_clr      (err_clr),
        .cfg_busy     (cfg_busy),
        .commit_cnt   (commit_cnt),
        .err_clip     (err_clip),
        .err_sync_ovr (err_sync_ovr)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int ch; int dly; } wr_t;
    wr_t exp_q[$];

    typedef struct { int ch; int dly; int exp_dly; int exp_clip; } vec_t;
    vec_t vecs[6];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard side: every write strobe must match the oldest expectation.
    always @(negedge clk) begin
        if (areset_n) begin
            if (ifc.cfg_wr_en) begin
                if (exp_q.size() == 0) begin
                    chk("wr_unexpected", 1, 0);
                end else begin
                    chk("wr_ch", int'(ifc.cfg_wr_ch), exp_q[0].ch);
                    chk("wr_dly", int'(ifc.cfg_wr_dly), exp_q[0].dly);
                    exp_q.delete(0);
                end
                if (ifc.commit_req) chk("wr_commit_overlap", 1, 0);
            end
            if (ifc.req_ready != '0) chk("ready_onehot", $countones(ifc.req_ready), 1);
        end
    end

    task automatic do_reset();
        areset_n = 1'b0;
        ifc.req_valid = '0;
        ifc.commit_ack = 1'b0;
        sync_in = 1'b0;
        err_clr = 1'b0;
        exp_q.delete();
        tick();
        tick();
        areset_n = 1'b1;
        tick();
    endtask

    // Single request from IDLE: ready one cycle later, write the cycle after.
    task automatic do_req(input int ch, input int dly, input int exp_dly);
        int n;
        ifc.req_dly[ch*W +: W] = W'(dly);
        ifc.req_valid[ch] = 1'b1;
        exp_q.push_back('{ch, exp_dly});
        n = 0;
        do begin
            tick();
            n++;
        end while (!ifc.req_ready[ch] && n < 20);
        chk("req_ready_latency", n, 1);
        ifc.req_valid[ch] = 1'b0;
        chk("busy_in_grant", int'(cfg_busy), 1);
        tick();
        chk("wr_en_latency", int'(ifc.cfg_wr_en), 1);
        chk("busy_in_write", int'(cfg_busy), 1);
        tick();
        chk("busy_back_idle", int'(cfg_busy), 0);
    endtask

    initial begin
        int n, last, bad;

        ifc.req_valid  = '0;
        ifc.req_dly    = '0;
        ifc.commit_ack = 1'b0;

        vecs[0] = '{2, 37, 37, 0};
        vecs[1] = '{1, 255, 200, 1};
        vecs[2] = '{1, 200, 200, 0};
        vecs[3] = '{3, 0, 0, 0};
        vecs[4] = '{0, 201, 200, 1};
        vecs[5] = '{0, 199, 199, 0};

        // reset state
        tick();
        tick();
        chk("rst_busy", int'(cfg_busy), 0);
        chk("rst_cnt", int'(commit_cnt), 0);
        chk("rst_err_clip", int'(err_clip), 0);
        chk("rst_err_ovr", int'(err_sync_ovr), 0);
        chk("rst_ready", int'(ifc.req_ready), 0);
        chk("rst_wr_en", int'(ifc.cfg_wr_en), 0);
        chk("rst_commit_req", int'(ifc.commit_req), 0);
        chk("rst_wr_dly", int'(ifc.cfg_wr_dly), 0);
        areset_n = 1'b1;
        tick();

        // table-driven single requests with clipping
        foreach (vecs[i]) begin
            err_clr = 1'b1;
            tick();
            err_clr = 1'b0;
            chk("clip_cleared", int'(err_clip), 0);
            do_req(vecs[i].ch, vecs[i].dly, vecs[i].exp_dly);
            chk("err_clip", int'(err_clip), vecs[i].exp_clip);
        end
        chk("vec_queue_drained", exp_q.size(), 0);

        // round-robin with all channels valid, pointer at 0
        do_reset();
        for (int c = 0; c < N; c++) ifc.req_dly[c*W +: W] = W'(10*c + 5);
        for (int g = 0; g < 5; g++) exp_q.push_back('{g % N, 10*(g % N) + 5});
        ifc.req_valid = '1;
        last = 0;
        for (int g = 0; g < 5; g++) begin
            n = 0;
            do begin
                tick();
                n++;
            end while (ifc.req_ready == '0 && n < 20);
            chk("rr_grant", int'(ifc.req_ready), 1 << (g % N));
            if (g > 0) chk("rr_spacing", cyc - last, 3);
            last = cyc;
        end
        ifc.req_valid = '0;
        repeat (3) tick();
        chk("rr_queue_drained", exp_q.size(), 0);

        // sync arriving in GRANT: write completes, then commit
        ifc.req_dly[0 +: W] = W'(50);
        ifc.req_valid[0] = 1'b1;
        exp_q.push_back('{0, 50});
        tick();
        chk("sw_ready", int'(ifc.req_ready), 1);
        ifc.req_valid[0] = 1'b0;
        sync_in = 1'b1;
        tick();
        sync_in = 1'b0;
        chk("sw_wr_en", int'(ifc.cfg_wr_en), 1);
        chk("sw_no_commit_in_write", int'(ifc.commit_req), 0);
        tick();
        chk("sw_no_commit_in_idle", int'(ifc.commit_req), 0);
        tick();
        chk("sw_commit_req", int'(ifc.commit_req), 1);
        chk("sw_cnt_before", int'(commit_cnt), 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("sw_commit_hold", int'(ifc.commit_req), 1);
        end
        ifc.commit_ack = 1'b1;
        tick();
        ifc.commit_ack = 1'b0;
        chk("sw_commit_fall", int'(ifc.commit_req), 0);
        chk("sw_cnt_after", int'(commit_cnt), 1);
        chk("sw_busy_after", int'(cfg_busy), 0);

        // sync overrun during commit
        sync_in = 1'b1;
        tick();
        sync_in = 1'b0;
        tick();
        chk("ovr_commit_req", int'(ifc.commit_req), 1);
        chk("ovr_err_before", int'(err_sync_ovr), 0);
        sync_in = 1'b1;
        tick();
        sync_in = 1'b0;
        chk("ovr_err_set", int'(err_sync_ovr), 1);
        tick();
        ifc.commit_ack = 1'b1;
        tick();
        ifc.commit_ack = 1'b0;
        chk("ovr_cnt", int'(commit_cnt), 2);
        repeat (6) tick();
        chk("ovr_single_commit", int'(commit_cnt), 2);
        chk("ovr_no_second_req", int'(ifc.commit_req), 0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("ovr_err_cleared", int'(err_sync_ovr), 0);

        // ack outside COMMIT is ignored
        ifc.commit_ack = 1'b1;
        tick();
        ifc.commit_ack = 1'b0;
        tick();
        chk("stray_ack_cnt", int'(commit_cnt), 2);

        // second sync while one is pending, coinciding with err_clr: set wins
        sync_in = 1'b1;
        tick();
        err_clr = 1'b1;
        tick();
        sync_in = 1'b0;
        err_clr = 1'b0;
        chk("setwins_err", int'(err_sync_ovr), 1);
        chk("setwins_commit_req", int'(ifc.commit_req), 1);
        ifc.commit_ack = 1'b1;
        tick();
        ifc.commit_ack = 1'b0;
        chk("setwins_cnt", int'(commit_cnt), 3);

        // reset while a commit is outstanding
        sync_in = 1'b1;
        tick();
        sync_in = 1'b0;
        tick();
        chk("rc_commit_req", int'(ifc.commit_req), 1);
        areset_n = 1'b0;
        #1;
        chk("rc_commit_req_0", int'(ifc.commit_req), 0);
        chk("rc_busy_0", int'(cfg_busy), 0);
        chk("rc_cnt_0", int'(commit_cnt), 0);
        chk("rc_err_ovr_0", int'(err_sync_ovr), 0);
        chk("rc_wr_en_0", int'(ifc.cfg_wr_en), 0);
        tick();
        tick();
        areset_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (ifc.cfg_wr_en || ifc.commit_req) bad++;
        end
        chk("rc_quiet_after", bad, 0);
        chk("rc_cnt_after", int'(commit_cnt), 0);
        chk("final_queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dec_dly_comp_ctrl.md
Name: dec_dly_comp_ctrl

Overview:
- Configuration scheduler for the decimation delay-compensation datapath (dec_dly_comp).
- Shares the datapath's single delay-table write port between N_CH channel requesters using round-robin arbitration.
- Range-clips requested delays.
- On each frame sync, sequences a shadow-to-active commit into the datapath with a req/ack handshake.

Parameters:
- N_CH, 4, number of requesting channels (2..8).
- DLY_W, 8, delay value width in samples.
- MAX_DLY, 200, largest legal delay; larger requests are clipped.
- CNT_W, 16, commit counter width.

Ports:
- clk  in  1  system clock.
- areset_n  in  1  asynchronous active-low reset.
- req_valid  in  N_CH  per-channel delay update request.
- req_dly  in  N_CH*DLY_W  per-channel requested delay; channel i at bits [i*DLY_W +: DLY_W].
- req_ready  out  N_CH  one-cycle accept pulse, per channel.
- sync_in  in  1  frame sync pulse, one cycle.
- cfg_wr_en  out  1  delay-table shadow write strobe.
- cfg_wr_ch  out  $clog2(N_CH)  channel index being written.
- cfg_wr_dly  out  DLY_W  clipped delay being written.
- commit_req  out  1  request to the datapath to copy shadow to active.
- commit_ack  in  1  datapath acknowledges the commit, one-cycle pulse.
- cfg_busy  out  1  controller is not in IDLE.
- commit_cnt  out  CNT_W  completed commits; wraps modulo 2^CNT_W.
- err_clip  out  1  sticky: a request exceeded MAX_DLY.
- err_sync_ovr  out  1  sticky: a sync was lost.
- err_clr  in  1  synchronous clear of both sticky errors.

Behaviour:
- Reset (async assert, sync release):
  - All outputs are 0.
  - FSM goes to IDLE, RR pointer to 0, sync_pend to 0.
  - Reset mid-transaction abandons that transaction; no write and no commit is emitted afterwards.
- FSM states: IDLE, GRANT, WRITE, COMMIT.
- IDLE:
  - If sync_pend=1, go to COMMIT. sync has priority over requests.
  - Else if any req_valid=1, choose the grant g: the first valid channel at or after the RR pointer, searching with wrap-around. Go to GRANT.
  - Else stay in IDLE.
- GRANT (1 cycle):
  - req_ready[g]=1 registered; only one bit of req_ready is ever high.
  - Capture req_dly[g]. If the value > MAX_DLY, store MAX_DLY and set err_clip.
  - RR pointer becomes (g+1) mod N_CH.
  - Go to WRITE.
- WRITE (1 cycle):
  - cfg_wr_en=1, with cfg_wr_ch=g and cfg_wr_dly equal to the clipped value.
  - Go to IDLE.
  - Latency: req_valid rising seen in IDLE at cycle t gives req_ready at t+1 and cfg_wr_en at t+2.
  - Requesters hold req_valid until they see req_ready.
- COMMIT:
  - Clear sync_pend on entry.
  - commit_req=1 until the cycle commit_ack=1 is sampled.
  - On commit_ack: commit_req=0 next cycle, commit_cnt+1, return to IDLE.
  - No time-out.
  - commit_ack outside COMMIT is ignored.
- sync_in handling:
  - In IDLE, GRANT or WRITE with sync_pend=0: set sync_pend. A write in flight completes before the commit starts.
  - In COMMIT, or when sync_pend is already 1: the sync is dropped and err_sync_ovr is set.
- Sticky errors:
  - err_clr clears both errors.
  - If err_clr coincides with a new error event, the set wins.
- cfg_busy = (state != IDLE), registered alongside the state.
- No write ever overlaps a commit.
- Boundary cases:
  - Valid data equal to MAX_DLY passes unclipped.
  - Delay 0 is legal.
  - RR pointer wraps from N_CH-1 to 0.

Decomposition:
- Package dec_dly_comp_ctrl_pkg holds:
  - the state enum typedef ctrl_state_t;
  - default constants for N_CH, DLY_W and MAX_DLY;
  - function clip_dly.
- Sub-module dec_dly_comp_rr_arb: combinational round-robin selector.
  - Inputs: req_valid and the pointer.
  - Outputs: grant index and any_valid.
  - The pointer register lives in the parent.

Test Plan:
- Single request: channel 2 asserts req_valid with dly=37 at cycle t in IDLE → req_ready[2] at t+1; cfg_wr_en at t+2 with ch=2, dly=37; cfg_busy high for t+1..t+2.
- Round-robin: all four channels valid continuously with pointer=0 → grants in order 0,1,2,3,0, each 3 cycles apart; exactly one req_ready bit high at a time.
- Clip: channel 1 requests dly=255 → cfg_wr_dly=200 and err_clip=1. Then err_clr → err_clip=0. Then dly=200 → written as 200 with err_clip staying 0.
- Sync during write:
  - sync_in in the GRANT cycle for channel 0 → the write completes first, then commit_req rises.
  - commit_ack returned 5 cycles later → commit_req falls next cycle; commit_cnt goes 0→1.
- Sync overrun: a second sync_in while commit_req is high awaiting ack → err_sync_ovr=1 and only one commit occurs (commit_cnt +1).
- Reset mid-COMMIT: assert areset_n=0 while commit_req=1 → all outputs 0 immediately. After release with no stimulus, no cfg_wr_en or commit_req appears; commit_cnt=0.
